// File: rtl/object_blitter.sv
// object_blitter: draws one 16x16 object from a synchronous object ROM at a
// requested screen position and emits it as VGA pixel writes.
// The pixels are emitted in raster order. Off-screen pixels are clipped.
// In erase mode the object footprint is filled with BG_COLOR.
// Optional build macro: OBJECT_BLITTER_TRANSPARENT_EN. When it is defined,
// draw mode does not plot ROM pixels equal to TRANSPARENT_COLOR.
module object_blitter #(
    parameter int          n                 = 8,
    parameter int          H_RES             = 160,
    parameter int          V_RES             = 120,
    parameter logic [23:0] BG_COLOR          = 24'h000000,
    parameter logic [23:0] TRANSPARENT_COLOR = 24'hFF00FF
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic          erase,
    input  logic [n-1:0]  x_pos,
    input  logic [n-2:0]  y_pos,
    output logic [7:0]    mem_addr,
    input  logic [23:0]   mem_data,
    output logic [n-1:0]  VGA_X,
    output logic [n-2:0]  VGA_Y,
    output logic [23:0]   VGA_COLOR,
    output logic          plot,
    output logic          busy,
    output logic          done
);

`ifdef OBJECT_BLITTER_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    localparam logic [n:0]   H_LIM = H_RES[n:0];
    localparam logic [n-1:0] V_LIM = V_RES[n-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_addr_q, mem_addr_d;
    logic          last_q, last_d;          // final ROM read has been issued
    logic [n-1:0]  x_lat_q, x_lat_d;
    logic [n-2:0]  y_lat_q, y_lat_d;
    logic          erase_q, erase_d;
    logic          pipe_valid_q, pipe_valid_d;
    logic [7:0]    pipe_addr_q, pipe_addr_d;  // address whose data is on mem_data
    logic [n-1:0]  vga_x_q, vga_x_d;
    logic [n-2:0]  vga_y_q, vga_y_d;
    logic [23:0]   vga_color_q, vga_color_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [n:0]    sum_x_s;
    logic [n-1:0]  sum_y_s;
    logic          in_bounds_s;
    logic          transparent_s;

    // Sequencer: accepts a start, walks the 256 ROM addresses, then flushes and signals done.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        last_d      = last_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        erase_d     = erase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_DRAW;
                    x_lat_d    = x_pos;
                    y_lat_d    = y_pos;
                    erase_d    = erase;
                    mem_addr_d = 8'd0;
                    last_d     = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_DRAW: begin
                // Address 255 is held for one extra cycle so its data can be captured.
                if (last_q) begin
                    state_d = S_FLUSH;
                end else if (mem_addr_q == 8'd255) begin
                    last_d  = 1'b1;
                end else begin
                    mem_addr_d = mem_addr_q + 8'd1;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d       = (state_d == S_DRAW) || (state_d == S_FLUSH);
        done_d       = (state_d == S_DONE);
        pipe_valid_d = (state_q == S_DRAW) && !last_q;
        pipe_addr_d  = mem_addr_q;
    end

    // Pixel stage: position, colour and clipped write strobe for the pixel whose ROM data is arriving.
    always_comb begin
        sum_x_s       = {1'b0, x_lat_q} + {{(n-3){1'b0}}, pipe_addr_q[3:0]};
        sum_y_s       = {1'b0, y_lat_q} + {{(n-4){1'b0}}, pipe_addr_q[7:4]};
        in_bounds_s   = (sum_x_s < H_LIM) && (sum_y_s < V_LIM);
        transparent_s = KEY_EN && !erase_q && (mem_data == TRANSPARENT_COLOR);
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_color_d   = vga_color_q;
        plot_d        = 1'b0;
        if (pipe_valid_q) begin
            vga_x_d     = sum_x_s[n-1:0];
            vga_y_d     = sum_y_s[n-2:0];
            vga_color_d = erase_q ? BG_COLOR : mem_data;
            plot_d      = in_bounds_s && !transparent_s;
        end else begin
            plot_d      = 1'b0;
        end
    end

    // State and output registers; reset aborts any draw in progress.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= 8'd0;
            last_q       <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            erase_q      <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_addr_q  <= 8'd0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= 24'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            last_q       <= last_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            erase_q      <= erase_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_color_q  <= vga_color_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_color_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_object_blitter.sv
// Scoreboard bench for object_blitter: each start pushes the expected pixel
// writes (with their cycle) and the done cycle; a negedge monitor pops and compares.
module tb_object_blitter;

`ifdef OBJECT_BLITTER_TRANSPARENT_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        start    = 1'b0;
    logic        erase    = 1'b0;
    logic [7:0]  x_pos    = 8'd0;
    logic [6:0]  y_pos    = 7'd0;
    logic [7:0]  mem_addr;
    logic [23:0] mem_data;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [23:0] VGA_COLOR;
    logic        plot, busy, done;

    logic [23:0] rom [256];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int plot_seen = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] c;
        int          t;
    } pix_t;
    pix_t exp_q[$];
    int   done_q[$];

    object_blitter dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .erase    (erase),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .VGA_X    (VGA_X),
        .VGA_Y    (VGA_Y),
        .VGA_COLOR(VGA_COLOR),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Cycle counter: value seen at a negedge equals the index of the preceding rising edge.
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Synchronous object ROM model.
    always @(posedge CLOCK_50) mem_data <= rom[mem_addr];

    // Monitor: compares every plot and done pulse against the scoreboard queues.
    always @(negedge CLOCK_50) begin
        pix_t e;
        int   dt;
        if (plot === 1'b1) begin
            plot_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d color=%h at cycle %0d, required no plot",
                         VGA_X, VGA_Y, VGA_COLOR, cyc);
            end else begin
                e = exp_q.pop_front();
                if (VGA_X !== e.x || VGA_Y !== e.y || VGA_COLOR !== e.c || cyc != e.t) begin
                    n_errors++;
                    $display("FAIL pixel: got x=%0d y=%0d color=%h cycle=%0d, required x=%0d y=%0d color=%h cycle=%0d",
                             VGA_X, VGA_Y, VGA_COLOR, cyc, e.x, e.y, e.c, e.t);
                end
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                dt = done_q.pop_front();
                if (cyc != dt || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_timing: got done at cycle %0d busy=%b, required cycle %0d busy=0",
                             cyc, busy, dt);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic fill_rom(input bit key_row0);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] b;
            b = k[7:0];
            rom[k] = (key_row0 && k < 16) ? 24'hFF00FF : {b, b, b};
        end
    endtask

    // Called at a negedge: pulses start, then loads the expected pixels and done cycle.
    task automatic issue_start(input logic [7:0] x, input logic [6:0] y, input logic e, output int t0);
        int xs, ys;
        logic [23:0] c;
        start = 1'b1;
        x_pos = x;
        y_pos = y;
        erase = e;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        t0 = cyc;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("addr_after_start", {24'd0, mem_addr}, 32'd0);
        exp_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            xs = int'(x) + (k % 16);
            ys = int'(y) + (k / 16);
            c  = e ? 24'h000000 : rom[k];
            if (xs < 160 && ys < 120 && !(TR && !e && rom[k] == 24'hFF00FF)) begin
                exp_q.push_back('{xs[7:0], ys[6:0], c, t0 + 2 + k});
                exp_cnt++;
            end
        end
        done_q.push_back(t0 + 258);
    endtask

    task automatic wait_done(input int t0, input int base);
        while (cyc < t0 + 257) @(negedge CLOCK_50);
        chk("busy_last_pixel", {31'd0, busy}, 32'd1);
        while (cyc < t0 + 259) @(negedge CLOCK_50);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("plot_count", plot_seen - base, exp_cnt);
        chk("pixels_left", exp_q.size(), 32'd0);
        chk("done_left", done_q.size(), 32'd0);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish, required finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, base;
        fill_rom(1'b0);
        repeat (3) @(negedge CLOCK_50);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_outputs", {VGA_X, 1'b0, VGA_Y, 16'd0}, 32'd0);
        chk("rst_color", {8'd0, VGA_COLOR}, 32'd0);
        chk("rst_flags", {29'd0, plot, busy, done}, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // Full in-bounds draw with the address pattern.
        base = plot_seen;
        issue_start(8'd72, 7'd52, 1'b0, t0);
        wait_done(t0, base);

        // Clipped at the bottom-right corner: 10x10 visible.
        base = plot_seen;
        issue_start(8'd150, 7'd110, 1'b0, t0);
        chk("clip_expected_100", exp_cnt, 32'd100);
        wait_done(t0, base);

        // Erase at origin.
        base = plot_seen;
        issue_start(8'd0, 7'd0, 1'b1, t0);
        wait_done(t0, base);

        // Starts during DRAW and in the done cycle are ignored; the next IDLE cycle starts a draw.
        base = plot_seen;
        issue_start(8'd20, 7'd30, 1'b0, t0);
        while (cyc < t0 + 50) @(negedge CLOCK_50);
        start = 1'b1; x_pos = 8'd3; y_pos = 7'd4;
        @(negedge CLOCK_50);
        start = 1'b0;
        while (cyc < t0 + 258) @(negedge CLOCK_50);
        start = 1'b1; x_pos = 8'd10; y_pos = 7'd20;
        @(negedge CLOCK_50);
        chk("busy_idle_after_done", {31'd0, busy}, 32'd0);
        chk("plot_count_first", plot_seen - base, exp_cnt);
        base = plot_seen;
        issue_start(8'd10, 7'd20, 1'b0, t1);
        wait_done(t1, base);

        // Reset at pixel 100 aborts the draw without a done pulse.
        issue_start(8'd40, 7'd40, 1'b0, t0);
        while (cyc < t0 + 102) @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        #1;
        chk("abort_addr", {24'd0, mem_addr}, 32'd0);
        chk("abort_xy", {VGA_X, 1'b0, VGA_Y, 16'd0}, 32'd0);
        chk("abort_color", {8'd0, VGA_COLOR}, 32'd0);
        chk("abort_flags", {29'd0, plot, busy, done}, 32'd0);
        exp_q.delete();
        done_q.delete();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (270) @(negedge CLOCK_50);
        chk("idle_after_abort", {30'd0, busy, done}, 32'd0);
        base = plot_seen;
        issue_start(8'd40, 7'd40, 1'b0, t0);
        wait_done(t0, base);

        // Row 0 holds the key colour; suppressed only when the feature is built in.
        fill_rom(1'b1);
        base = plot_seen;
        issue_start(8'd5, 7'd5, 1'b0, t0);
        chk("key_expected_cnt", exp_cnt, TR ? 32'd240 : 32'd256);
        wait_done(t0, base);
        base = plot_seen;
        issue_start(8'd5, 7'd5, 1'b1, t0);
        wait_done(t0, base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
